// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-of-3 majority bit sampling, parity/stop checking, break
// detection and a small receive FIFO holding {frame_err, parity_err, data}.
module uart_rx_fifo #(
  parameter int unsigned CLK_FRE    = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int unsigned BPS  = CLK_FRE / BAUD_RATE;
  localparam int unsigned HALF = BPS / 2;
  localparam int unsigned CW   = $clog2(BPS);
  localparam int unsigned BW   = $clog2(DATA_BITS);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned EW   = DATA_BITS + 2;

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  state_e                 state_q, state_d;
  logic                   rx_s1_q, rx_s2_q, rx_prev_q;
  logic                   armed_q, armed_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [1:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d, pbit_q, pbit_d;
  logic                   overrun_q, break_q;
  logic                   commit, brk, maj, at_dec, at_end;
  logic [AW:0]            wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          head;
  logic                   full, pop, push;

  assign at_dec = (cnt_q == CW'(HALF + 1));
  assign at_end = (cnt_q == CW'(BPS - 1));
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = (state_q == StIdle || at_end) ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    stop_d  = stop_q;
    samp_d  = samp_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    pbit_d  = pbit_q;
    commit  = 1'b0;
    brk     = 1'b0;
    if (cnt_q == CW'(HALF - 1)) samp_d[0] = rx_s2_q;
    if (cnt_q == CW'(HALF))     samp_d[1] = rx_s2_q;
    unique case (state_q)
      StIdle: begin
        if (rx_s2_q) armed_d = 1'b1;
        // armed_q blocks starts until the line has been seen high after reset or a break
        if (armed_q && rx_prev_q && !rx_s2_q) begin
          state_d = StStart;
          cnt_d   = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          data_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          pbit_d  = 1'b0;
        end
      end
      StStart: begin
        if (at_dec && maj) state_d = StIdle;
        else if (at_end)   state_d = StData;
      end
      StData: begin
        if (at_dec) data_d = {maj, data_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? StPar : StStop;
          else                             bit_d   = bit_q + BW'(1);
        end
      end
      StPar: begin
        if (at_dec) begin
          pbit_d = maj;
          perr_d = (PARITY == 1) ? ~(^data_q ^ maj) : (^data_q ^ maj);
        end
        if (at_end) state_d = StStop;
      end
      StStop: begin
        if (at_dec) begin
          if (!stop_q && !maj && data_q == '0 && !pbit_q) begin
            brk     = 1'b1;
            armed_d = 1'b0;
            state_d = StIdle;
          end else if (stop_q == 1'(STOP_BITS - 1)) begin
            commit  = 1'b1;
            state_d = StIdle;
          end else if (!maj) begin
            ferr_d = 1'b1;
          end
        end else if (at_end) begin
          stop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      armed_q   <= 1'b0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      samp_q    <= '0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      pbit_q    <= 1'b0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      armed_q   <= armed_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      samp_q    <= samp_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      pbit_q    <= pbit_d;
      overrun_q <= commit && full && !pop;
      break_q   <= brk;
      if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  // Storage is not reset; outputs are gated by rx_valid so stale contents never show.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {ferr_q | ~maj, perr_q, data_q};
  end

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = rx_valid && rx_ready;
  assign push  = commit && (!full || pop);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign rx_valid      = (wr_ptr_q != rd_ptr_q);
  assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_parity_err = rx_valid & head[DATA_BITS];
  assign rx_frame_err  = rx_valid & head[DATA_BITS+1];
  assign rx_busy       = (state_q != StIdle);
  assign overrun       = overrun_q;
  assign break_det     = break_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: default-config instance plus an even-parity
// instance, with a queue of expected FIFO entries compared as the DUT presents them.
module tb_uart_rx_fifo;

  localparam int BPS = 434;

  logic       clk, rst;
  logic       uart_rx, rx_ready, uart_rx_p, rx_ready_p;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_parity_err, rx_frame_err, rx_valid, rx_busy, overrun, break_det;
  logic       rx_parity_err_p, rx_frame_err_p, rx_valid_p, rx_busy_p, overrun_p, break_det_p;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;
  bit vseen = 0;
  bit bseen = 0;
  bit p_evt = 0;
  logic [9:0] exp_q[$];

  uart_rx_fifo u_dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_busy(rx_busy), .overrun(overrun), .break_det(break_det)
  );

  uart_rx_fifo #(.PARITY(2)) u_dut_par (
    .clk(clk), .rst(rst), .uart_rx(uart_rx_p), .rx_data(rx_data_p),
    .rx_parity_err(rx_parity_err_p), .rx_frame_err(rx_frame_err_p), .rx_valid(rx_valid_p),
    .rx_ready(rx_ready_p), .rx_busy(rx_busy_p), .overrun(overrun_p), .break_det(break_det_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
    if (overrun)   ovr_cnt++;
    if (break_det) brk_cnt++;
    if (rx_valid)  vseen = 1'b1;
    if (rx_busy)   bseen = 1'b1;
    if (overrun_p || break_det_p) p_evt = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) uart_rx = v;
    else          uart_rx_p = v;
  endtask

  // Drives start, data (LSB first) and optional parity; returns as the stop bit begins.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit with_par,
                            input logic pbit);
    set_line(sel, 1'b0);
    idle(BPS);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      idle(BPS);
    end
    if (with_par) begin
      set_line(sel, pbit);
      idle(BPS);
    end
    set_line(sel, 1'b1);
  endtask

  task automatic wait_valid(input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * BPS; i++) begin
      if ((sel == 0) ? rx_valid : rx_valid_p) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    uart_rx_p = 1'b1;
    rx_ready = 1'b0;
    rx_ready_p = 1'b1;
    idle(4);
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++;
    if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    checks++;
    if ({overrun, break_det} !== 2'b00) begin
      failures++; $display("FAIL reset_pulses got=%b exp=00", {overrun, break_det});
    end
    checks++;
    if ({rx_frame_err, rx_parity_err, rx_data} !== 10'h000) begin
      failures++;
      $display("FAIL reset_head got=%h exp=000", {rx_frame_err, rx_parity_err, rx_data});
    end
    rst = 1'b0;
    idle(8);
  endtask

  task automatic test_basic();
    bit ok;
    logic [9:0] got, exp;
    rx_ready = 1'b1;
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(0, 8'h5A, 1'b0, 1'b0);
    wait_valid(0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout got=none exp=valid"); end
    else begin
      got = {rx_frame_err, rx_parity_err, rx_data};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL basic_entry got=%h exp=%h", got, exp); end
      tick();
      checks++;
      if (rx_valid !== 1'b0) begin
        failures++; $display("FAIL basic_valid_1cycle got=%b exp=0", rx_valid);
      end
    end
    idle(BPS);
    checks++;
    if (rx_busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", rx_busy); end
  endtask

  task automatic test_parity();
    bit ok;
    logic [9:0] got, exp;
    p_evt = 1'b0;
    exp_q.push_back({2'b01, 8'h07});
    send_frame(1, 8'h07, 1'b1, 1'b0);
    wait_valid(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL parity_timeout got=none exp=valid"); end
    else begin
      got = {rx_frame_err_p, rx_parity_err_p, rx_data_p};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL parity_entry got=%h exp=%h", got, exp); end
    end
    idle(BPS);
    checks++;
    if ({p_evt, rx_busy_p} !== 2'b00) begin
      failures++; $display("FAIL parity_side got=%b exp=00", {p_evt, rx_busy_p});
    end
  endtask

  task automatic test_glitch();
    vseen = 1'b0;
    bseen = 1'b0;
    uart_rx = 1'b0;
    idle(100);
    uart_rx = 1'b1;
    checks++;
    if (bseen !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise got=%b exp=1", bseen); end
    for (int i = 0; i < BPS; i++) begin
      if (!rx_busy) break;
      tick();
    end
    checks++;
    if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_fall got=%b exp=0", rx_busy); end
    idle(BPS);
    checks++;
    if (vseen !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", vseen); end
  endtask

  task automatic test_overrun();
    int occ = 0;
    int exp_ovr = 0;
    logic [9:0] got, exp;
    rx_ready = 1'b0;
    ovr_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      if (occ < 4) begin
        exp_q.push_back({2'b00, 8'(k)});
        occ++;
      end else begin
        exp_ovr++;
      end
      send_frame(0, 8'(k), 1'b0, 1'b0);
      idle(BPS);
    end
    checks++;
    if (ovr_cnt != exp_ovr) begin
      failures++; $display("FAIL overrun_pulses got=%0d exp=%0d", ovr_cnt, exp_ovr);
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {rx_frame_err, rx_parity_err, rx_data};
      checks++;
      if (rx_valid !== 1'b1 || got !== exp) begin
        failures++; $display("FAIL overrun_pop got=%b/%h exp=1/%h", rx_valid, got, exp);
      end
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL overrun_empty got=%b exp=0", rx_valid); end
  endtask

  task automatic test_break();
    logic [9:0] got, exp;
    rx_ready = 1'b0;
    brk_cnt = 0;
    ovr_cnt = 0;
    exp_q.push_back({2'b00, 8'h11});
    send_frame(0, 8'h11, 1'b0, 1'b0);
    idle(BPS);
    uart_rx = 1'b0;
    idle(12 * BPS);
    uart_rx = 1'b1;
    idle(2 * BPS);
    checks++;
    if (brk_cnt != 1) begin failures++; $display("FAIL break_pulses got=%0d exp=1", brk_cnt); end
    checks++;
    if (ovr_cnt != 0) begin failures++; $display("FAIL break_overrun got=%0d exp=0", ovr_cnt); end
    exp_q.push_back({2'b00, 8'hA5});
    send_frame(0, 8'hA5, 1'b0, 1'b0);
    idle(BPS);
    for (int n = 0; n < 2; n++) begin
      exp = exp_q.pop_front();
      got = {rx_frame_err, rx_parity_err, rx_data};
      checks++;
      if (rx_valid !== 1'b1 || got !== exp) begin
        failures++; $display("FAIL break_fifo got=%b/%h exp=1/%h", rx_valid, got, exp);
      end
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL break_empty got=%b exp=0", rx_valid); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [7:0] d = 8'h3C;
    logic [9:0] got, exp;
    rx_ready = 1'b1;
    uart_rx = 1'b0;
    idle(BPS);
    for (int i = 0; i < 3; i++) begin
      uart_rx = d[i];
      idle(BPS);
    end
    uart_rx = d[3];
    idle(BPS / 2);
    checks++;
    if (rx_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_pre got=%b exp=1", rx_busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (rx_busy !== 1'b0) begin failures++; $display("FAIL midrst_async got=%b exp=0", rx_busy); end
    uart_rx = 1'b1;
    idle(3);
    rst = 1'b0;
    vseen = 1'b0;
    idle(2 * BPS);
    checks++;
    if ({vseen, rx_busy} !== 2'b00) begin
      failures++; $display("FAIL midrst_discard got=%b exp=00", {vseen, rx_busy});
    end
    exp_q.push_back({2'b00, 8'hC3});
    send_frame(0, 8'hC3, 1'b0, 1'b0);
    wait_valid(0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midrst_timeout got=none exp=valid"); end
    else begin
      got = {rx_frame_err, rx_parity_err, rx_data};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL midrst_entry got=%h exp=%h", got, exp); end
    end
    idle(BPS);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_overrun();
    test_break();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50_000_000, meaning the clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning the line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning the data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning the stop bits checked per frame, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries, a power of 2 in 2..16.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-009 SHALL have port uart_rx, input, 1 bit, the asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data, output, DATA_BITS bits, the FIFO head data word.
REQ-011 SHALL have port rx_parity_err, output, 1 bit, the parity error flag of the FIFO head entry.
REQ-012 SHALL have port rx_frame_err, output, 1 bit, the stop-bit error flag of the FIFO head entry.
REQ-013 SHALL have port rx_valid, output, 1 bit, high when the FIFO is non-empty.
REQ-014 SHALL have port rx_ready, input, 1 bit, the consumer accept strobe.
REQ-015 SHALL have port rx_busy, output, 1 bit, high whenever the FSM is not IDLE.
REQ-016 SHALL have port overrun, output, 1 bit, a 1-cycle pulse when a frame is dropped because the FIFO is full.
REQ-017 SHALL have port break_det, output, 1 bit, a 1-cycle pulse on a detected line break.

Function
REQ-018 SHALL synchronise uart_rx through 2 flops, each reset to 1.
REQ-019 SHALL use bit period BPS = CLK_FRE/BAUD_RATE clocks (integer divide).
REQ-020 SHALL count each bit period 0..BPS-1 with a counter restarted at start detection.
REQ-021 SHALL decide each bit by a 2-of-3 majority of samples taken at counts BPS/2-1, BPS/2 and BPS/2+1.
REQ-022 SHALL implement FSM states IDLE, START, DATA, PAR and STOP.
REQ-023 SHALL go IDLE->START on a synchronised 1->0 edge.
REQ-024 SHALL, in START, return to IDLE with no output if the start-bit majority is 1 (glitch reject); otherwise go to DATA at the end of the bit period.
REQ-025 SHALL shift in DATA_BITS bits in DATA, LSB first.
REQ-026 SHALL then go to PAR if PARITY!=0, else to STOP.
REQ-027 SHALL, in PAR, set the parity error when the XOR of data and parity bit is not 1 (odd) or not 0 (even).
REQ-028 SHALL, in STOP, check STOP_BITS bits and set the frame error if any stop majority is 0.
REQ-029 SHALL commit the frame at the sample decision (count BPS/2+1) of the last stop bit, then go to IDLE in the same cycle so the next start edge is accepted.
REQ-030 SHALL, on break (all data 0, parity bit 0 if present, first stop bit 0), pulse break_det and not write the FIFO.
REQ-031 SHALL, after a break, wait in IDLE for the line to read 1 before any new start edge is accepted.
REQ-032 SHALL store {frame_err, parity_err, data} per commit in the FIFO; parity_err SHALL be 0 when PARITY=0.
REQ-033 SHALL pop the FIFO on rx_valid && rx_ready.
REQ-034 SHALL assert rx_valid the cycle after a commit into an empty FIFO.
REQ-035 SHALL ignore rx_ready while rx_valid is low.
REQ-036 SHALL, on commit into a full FIFO with no pop that cycle, drop the new frame, keep existing contents and pulse overrun.
REQ-037 SHALL, on commit into a full FIFO with a pop in the same cycle, accept both, with no overrun.
REQ-038 SHALL size FIFO pointers at log2(FIFO_DEPTH)+1 bits so they wrap without ambiguity between full and empty.

Reset
REQ-039 SHALL, on rst high, immediately (asynchronously) place the FSM in IDLE, empty the FIFO, zero all counters, and drive rx_valid, rx_busy, overrun, break_det, rx_parity_err, rx_frame_err and rx_data to 0.
REQ-040 SHALL, on reset asserted mid-frame, discard the partial frame; after release, reception SHALL resume only on a fresh falling edge.

Verification
REQ-041 SHALL cover: defaults (BPS=434), frame 0x5A, rx_ready=1 -> rx_data=0x5A, rx_valid 1 cycle, no error flags.
REQ-042 SHALL cover: PARITY=2, send 0x07 with parity bit 0 -> entry 0x07 with rx_parity_err=1.
REQ-043 SHALL cover: 100-clock low glitch on idle line -> no rx_valid, rx_busy back to 0 within 1 bit period.
REQ-044 SHALL cover: FIFO_DEPTH=4, rx_ready=0, send 5 frames 0x01..0x05 -> one overrun pulse, then pops yield 0x01..0x04.
REQ-045 SHALL cover: line held low for 12 bit periods -> one break_det pulse, FIFO unchanged, next frame 0xA5 received correctly after line high.
REQ-046 SHALL cover: rst asserted during DATA of frame 0x3C, released, then frame 0xC3 sent -> only 0xC3 appears.
